// File: rtl/udp_tx_arbiter.sv
// Frame-level 2:1 AXI-Stream byte arbiter feeding the Ethernet MAC TX port.
// Port 0 carries UDP ACKs and port 1 carries order/data frames. Each grant lasts one whole frame.
module udp_tx_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int GAP_CYCLES    = 12,
    parameter int MAX_BEATS     = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    output logic        s0_axis_tready,
    input  logic        s0_axis_tlast,
    input  logic [7:0]  s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    output logic        s1_axis_tready,
    input  logic        s1_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_overlength,
    output logic [15:0] o_frames_0,
    output logic [15:0] o_frames_1
);

    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [11:0] BEAT_LAST = 12'(MAX_BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_GAP} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    grant_reg, grant_next;
    logic          last_reg, last_next;
    logic [11:0]   beat_cnt_reg, beat_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          overlength_reg, overlength_next;
    logic [1:0]    frame_done;
    logic          frame_end;
    logic          win;

    logic       sel;
    logic [7:0] src_tdata;
    logic       src_tvalid;
    logic       src_tlast;

    assign sel        = grant_reg[1];
    assign src_tdata  = sel ? s1_axis_tdata  : s0_axis_tdata;
    assign src_tvalid = sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign src_tlast  = sel ? s1_axis_tlast  : s0_axis_tlast;

    // win = 1 selects port 1; last_reg holds the index of the port granted last.
    always_comb begin
        if (s0_axis_tvalid && s1_axis_tvalid)
            win = (PRIORITY_MODE == 0) ? 1'b0 : ~last_reg;
        else
            win = s1_axis_tvalid;
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_next       = last_reg;
        beat_cnt_next   = beat_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        overlength_next = 1'b0;
        frame_done      = 2'b00;
        frame_end       = 1'b0;
        m_axis_tdata    = 8'h00;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        s0_axis_tready  = 1'b0;
        s1_axis_tready  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    grant_next    = win ? 2'b10 : 2'b01;
                    beat_cnt_next = '0;
                    state_next    = ST_XFER;
                end
            end
            ST_XFER: begin
                m_axis_tdata   = src_tdata;
                m_axis_tvalid  = src_tvalid;
                m_axis_tlast   = src_tlast;
                s0_axis_tready = grant_reg[0] & m_axis_tready;
                s1_axis_tready = grant_reg[1] & m_axis_tready;
                if (src_tvalid && m_axis_tready) begin
                    beat_cnt_next = beat_cnt_reg + 12'd1;
                    if (src_tlast) begin
                        frame_done = grant_reg;
                        last_next  = sel;
                        frame_end  = 1'b1;
                    end else if (beat_cnt_reg == BEAT_LAST) begin
                        // Runaway frame: close it towards the MAC, swallow the rest in DRAIN.
                        m_axis_tlast    = 1'b1;
                        overlength_next = 1'b1;
                        frame_done      = grant_reg;
                        last_next       = sel;
                        state_next      = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s0_axis_tready = grant_reg[0];
                s1_axis_tready = grant_reg[1];
                if (src_tvalid && src_tlast)
                    frame_end = 1'b1;
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0)
                    state_next = ST_IDLE;
                else
                    gap_cnt_next = gap_cnt_reg - 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        if (frame_end) begin
            grant_next = 2'b00;
            if (GAP_CYCLES > 0) begin
                state_next   = ST_GAP;
                gap_cnt_next = GAP_LOAD;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 2'b00;
            last_reg       <= 1'b1;
            beat_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            overlength_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_reg       <= last_next;
            beat_cnt_reg   <= beat_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            overlength_reg <= overlength_next;
        end
    end

    // Per-port completed-frame counters, free-running and wrapping.
    for (genvar gi = 0; gi < 2; gi++) begin : g_frames
        logic [15:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg <= '0;
            else if (frame_done[gi])
                cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign o_frames_0   = g_frames[0].cnt_reg;
    assign o_frames_1   = g_frames[1].cnt_reg;
    assign o_grant      = grant_reg;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_overlength = overlength_reg;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: three instances (fixed priority, round-robin, MAX_BEATS=16)
// fed from queued sources, with output beats checked against a per-instance scoreboard.
module tb_udp_tx_arbiter;

    typedef struct packed {logic l; logic [7:0] d;} beat_t;
    typedef struct packed {logic [1:0] g; logic l; logic [7:0] d;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata  [3][2];
    logic        s_tvalid [3][2];
    logic        s_tready [3][2];
    logic        s_tlast  [3][2];
    logic [7:0]  m_tdata  [3];
    logic        m_tvalid [3];
    logic        m_tready [3];
    logic        m_tlast  [3];
    logic [1:0]  grant    [3];
    logic        busy     [3];
    logic        ovl      [3];
    logic [15:0] frames0  [3];
    logic [15:0] frames1  [3];

    beat_t src_q [3][2][$];
    exp_t  exp_q [3][$];
    int    out_beats [3];
    int    ovl_cnt   [3];
    bit    rand_rdy  [3];

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        udp_tx_arbiter #(
            .PRIORITY_MODE((gi == 1) ? 1 : 0),
            .GAP_CYCLES   (12),
            .MAX_BEATS    ((gi == 2) ? 16 : 1518)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .s0_axis_tdata (s_tdata[gi][0]),
            .s0_axis_tvalid(s_tvalid[gi][0]),
            .s0_axis_tready(s_tready[gi][0]),
            .s0_axis_tlast (s_tlast[gi][0]),
            .s1_axis_tdata (s_tdata[gi][1]),
            .s1_axis_tvalid(s_tvalid[gi][1]),
            .s1_axis_tready(s_tready[gi][1]),
            .s1_axis_tlast (s_tlast[gi][1]),
            .m_axis_tdata  (m_tdata[gi]),
            .m_axis_tvalid (m_tvalid[gi]),
            .m_axis_tready (m_tready[gi]),
            .m_axis_tlast  (m_tlast[gi]),
            .o_grant       (grant[gi]),
            .o_busy        (busy[gi]),
            .o_overlength  (ovl[gi]),
            .o_frames_0    (frames0[gi]),
            .o_frames_1    (frames1[gi])
        );

        // Sink ready: always 1, or a 50% coin flip when rand_rdy is set.
        initial begin
            m_tready[gi] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                m_tready[gi] = rand_rdy[gi] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        // Output monitor: ready mirroring while transferring, then scoreboard compare.
        initial begin
            exp_t e;
            int   gp;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (ovl[gi]) ovl_cnt[gi]++;
                    if (m_tvalid[gi]) begin
                        gp = grant[gi][1] ? 1 : 0;
                        check("tready_mirror", 32'(s_tready[gi][gp]), 32'(m_tready[gi]));
                        check("tready_ungranted", 32'(s_tready[gi][1-gp]), 32'd0);
                    end
                    if (m_tvalid[gi] && m_tready[gi]) begin
                        out_beats[gi]++;
                        if (exp_q[gi].size() == 0) begin
                            n_asserts++;
                            n_fail++;
                            $error("FAIL unexpected_beat inst=%0d observed=0x%0h expected=none",
                                   gi, {grant[gi], m_tlast[gi], m_tdata[gi]});
                        end else begin
                            e = exp_q[gi].pop_front();
                            check("beat", 32'({grant[gi], m_tlast[gi], m_tdata[gi]}), 32'(e));
                        end
                    end
                end
            end
        end

        for (genvar gj = 0; gj < 2; gj++) begin : g_src
            // Source model: handshake sampled mid-cycle, next beat presented after the edge.
            initial begin
                bit hs;
                s_tvalid[gi][gj] = 1'b0;
                s_tdata[gi][gj]  = 8'h00;
                s_tlast[gi][gj]  = 1'b0;
                forever begin
                    @(negedge clk);
                    hs = s_tvalid[gi][gj] && s_tready[gi][gj];
                    @(posedge clk);
                    #1;
                    if (rst) begin
                        src_q[gi][gj].delete();
                    end else if (hs && src_q[gi][gj].size() > 0) begin
                        void'(src_q[gi][gj].pop_front());
                    end
                    if (!rst && src_q[gi][gj].size() > 0) begin
                        s_tvalid[gi][gj] = 1'b1;
                        s_tdata[gi][gj]  = src_q[gi][gj][0].d;
                        s_tlast[gi][gj]  = src_q[gi][gj][0].l;
                    end else begin
                        s_tvalid[gi][gj] = 1'b0;
                        s_tdata[gi][gj]  = 8'h00;
                        s_tlast[gi][gj]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic src_push(input int k, input int p, input int len, input logic [7:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = base + 8'(i);
            b.l = (i == len - 1);
            src_q[k][p].push_back(b);
        end
    endtask

    task automatic exp_push(input int k, input int p, input int len, input logic [7:0] base,
                            input int maxb);
        exp_t e;
        int   n;
        n = (len < maxb) ? len : maxb;
        for (int i = 0; i < n; i++) begin
            e.g = (p == 1) ? 2'b10 : 2'b01;
            e.d = base + 8'(i);
            e.l = (i == n - 1);
            exp_q[k].push_back(e);
        end
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (!(src_q[k][0].size() == 0 && src_q[k][1].size() == 0 &&
                 exp_q[k].size() == 0 && !busy[k]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("idle_within_budget", 32'(t < 5000), 32'd1);
    endtask

    // Waits for a frame's final output beat, then counts the busy cycles that follow it.
    task automatic measure_gap(input int k, output int n);
        int t;
        n = 0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m_tvalid[k] && m_tready[k] && m_tlast[k]) && t < 3000);
        check("last_beat_seen", 32'(t < 3000), 32'd1);
        t = 0;
        forever begin
            @(negedge clk);
            t++;
            if (!busy[k] || t > 100) break;
            n++;
        end
    endtask

    initial begin
        int gap;
        int t;
        int start;
        for (int k = 0; k < 3; k++) begin
            out_beats[k] = 0;
            ovl_cnt[k]   = 0;
            rand_rdy[k]  = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_grant", 32'(grant[k]), 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_overlength", 32'(ovl[k]), 32'd0);
            check("rst_frames0", 32'(frames0[k]), 32'd0);
            check("rst_frames1", 32'(frames1[k]), 32'd0);
            check("rst_m_tvalid", 32'(m_tvalid[k]), 32'd0);
        end

        // Single 60-beat frame on port 0
        src_push(0, 0, 60, 8'h10);
        exp_push(0, 0, 60, 8'h10, 1518);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_tvalid[0] && t < 100);
        check("xfer_started", 32'(t < 100), 32'd1);
        check("xfer_grant", 32'(grant[0]), 32'd1);
        measure_gap(0, gap);
        check("gap_after_single", 32'(gap), 32'd12);
        wait_idle(0);
        check("single_frames0", 32'(frames0[0]), 32'd1);

        // Tie, fixed priority: all port-0 frames before port-1 frames
        src_push(0, 0, 5, 8'h20); src_push(0, 0, 7, 8'h30); src_push(0, 0, 9, 8'h40);
        src_push(0, 1, 6, 8'hA0); src_push(0, 1, 8, 8'hB0); src_push(0, 1, 4, 8'hC0);
        exp_push(0, 0, 5, 8'h20, 1518); exp_push(0, 0, 7, 8'h30, 1518);
        exp_push(0, 0, 9, 8'h40, 1518); exp_push(0, 1, 6, 8'hA0, 1518);
        exp_push(0, 1, 8, 8'hB0, 1518); exp_push(0, 1, 4, 8'hC0, 1518);
        wait_idle(0);
        check("prio_frames0", 32'(frames0[0]), 32'd4);
        check("prio_frames1", 32'(frames1[0]), 32'd3);

        // Tie, round-robin: alternating grants with a 12-cycle gap after each frame
        src_push(1, 0, 5, 8'h20); src_push(1, 0, 7, 8'h30); src_push(1, 0, 9, 8'h40);
        src_push(1, 1, 6, 8'hA0); src_push(1, 1, 8, 8'hB0); src_push(1, 1, 4, 8'hC0);
        exp_push(1, 0, 5, 8'h20, 1518); exp_push(1, 1, 6, 8'hA0, 1518);
        exp_push(1, 0, 7, 8'h30, 1518); exp_push(1, 1, 8, 8'hB0, 1518);
        exp_push(1, 0, 9, 8'h40, 1518); exp_push(1, 1, 4, 8'hC0, 1518);
        for (int f = 0; f < 6; f++) begin
            measure_gap(1, gap);
            check("rr_gap", 32'(gap), 32'd12);
        end
        wait_idle(1);
        check("rr_frames0", 32'(frames0[1]), 32'd3);
        check("rr_frames1", 32'(frames1[1]), 32'd3);

        // 100-beat port-1 frame under random backpressure
        rand_rdy[0] = 1'b1;
        start = out_beats[0];
        src_push(0, 1, 100, 8'hC8);
        exp_push(0, 1, 100, 8'hC8, 1518);
        wait_idle(0);
        rand_rdy[0] = 1'b0;
        check("bp_beat_count", 32'(out_beats[0] - start), 32'd100);
        check("bp_frames1", 32'(frames1[0]), 32'd4);

        // Runaway 20-beat frame against MAX_BEATS=16
        src_push(2, 0, 20, 8'h50);
        exp_push(2, 0, 20, 8'h50, 16);
        wait_idle(2);
        check("trunc_overlength_pulses", 32'(ovl_cnt[2]), 32'd1);
        check("trunc_frames0", 32'(frames0[2]), 32'd1);
        check("trunc_beats", 32'(out_beats[2]), 32'd16);
        check("no_overlength_inst0", 32'(ovl_cnt[0]), 32'd0);

        // Reset in the middle of a 60-beat frame, then a fresh frame
        start = out_beats[0];
        src_push(0, 0, 60, 8'h60);
        exp_push(0, 0, 60, 8'h60, 1518);
        t = 0;
        while (out_beats[0] - start < 30 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reached_beat30", 32'(t < 500), 32'd1);
        #1;
        rst = 1'b1;
        exp_q[0].delete();
        @(negedge clk);
        check("midrst_m_tvalid", 32'(m_tvalid[0]), 32'd0);
        check("midrst_grant", 32'(grant[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_frames0", 32'(frames0[0]), 32'd0);
        check("midrst_frames1", 32'(frames1[0]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        src_push(0, 1, 10, 8'h70);
        exp_push(0, 1, 10, 8'h70, 1518);
        wait_idle(0);
        check("post_rst_frames1", 32'(frames1[0]), 32'd1);
        check("post_rst_frames0", 32'(frames0[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Frame-level 2:1 AXI-Stream byte arbiter between the UDP TX sources and the Ethernet MAC TX interface.
- Port 0 carries the UDP ACK generator stream; port 1 carries the order/data UDP stream.
- Grants one whole frame (first beat to tlast) at a time and enforces a minimum idle gap between frames.
- Truncates runaway frames and keeps per-port frame counters.

Parameters:
- PRIORITY_MODE, 0, 0 = fixed priority (port 0 wins ties); 1 = round-robin (port not granted last wins ties).
- GAP_CYCLES, 12, idle cycles inserted after each frame's final beat; 0 = no gap state.
- MAX_BEATS, 1518, maximum beats forwarded per frame before forced truncation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s0_axis_tdata  in  8  port 0 (ACK) data
- s0_axis_tvalid  in  1  port 0 valid
- s0_axis_tready  out  1  port 0 ready
- s0_axis_tlast  in  1  port 0 last beat of frame
- s1_axis_tdata  in  8  port 1 (data) data
- s1_axis_tvalid  in  1  port 1 valid
- s1_axis_tready  out  1  port 1 ready
- s1_axis_tlast  in  1  port 1 last beat
- m_axis_tdata  out  8  to MAC
- m_axis_tvalid  out  1  to MAC
- m_axis_tready  in  1  from MAC
- m_axis_tlast  out  1  to MAC
- o_grant  out  2  one-hot current grant; 00 when no grant
- o_busy  out  1  high in any state other than IDLE
- o_overlength  out  1  one-cycle pulse when a frame is truncated
- o_frames_0  out  16  frames completed on port 0; wraps
- o_frames_1  out  16  frames completed on port 1; wraps

Behaviour:
- Clock and reset: single clk domain; rst synchronous, active-high.
- Reset values: state IDLE; o_grant 00; o_busy, o_overlength 0; o_frames_0/1 0; last-granted = port 1, so port 0 wins the first round-robin tie.
- Beat definition: a beat transfers when tvalid && tready on the same interface.
- Transfer signalling: in IDLE, GAP and DRAIN, m_axis_tvalid = 0. m_axis_tdata is don't-care when m_axis_tvalid = 0.
- Source ready: a port's s_tready is 1 only as follows:
  - in XFER, if that port is granted;
  - in DRAIN, for the granted port;
  - 0 in all other cases.
- States:
  - IDLE:
    - If any s_tvalid is high, pick the winner per PRIORITY_MODE, register grant, then go to XFER.
    - Arbitration latency is 1 cycle: no data passes in the decision cycle.
    - Both valid with PRIORITY_MODE=0: port 0 wins.
    - Both valid with PRIORITY_MODE=1: the port not granted last wins.
  - XFER:
    - Zero-latency pass-through. m_tdata/m_tvalid/m_tlast = granted port's tdata/tvalid/tlast. Granted s_tready = m_axis_tready. Ungranted s_tready = 0.
    - A 12-bit beat counter increments per output beat.
    - Beat with source tlast: increment that port's frame counter and update last-granted. If GAP_CYCLES>0, go to GAP; otherwise go to IDLE.
    - Beat number MAX_BEATS without source tlast: force m_axis_tlast=1 on that beat and pulse o_overlength the following cycle. Also increment the frame counter and update last-granted.
    - After truncation, go to DRAIN.
  - DRAIN:
    - Granted s_tready = 1 and beats are discarded.
    - On the source's tlast beat, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP:
    - Counter loads GAP_CYCLES-1 on entry and counts down.
    - Go to IDLE when the counter reaches 0, giving exactly GAP_CYCLES idle cycles.
    - Requests arriving during GAP are held; the sources stall.
- Backpressure: m_axis_tready low stalls the granted source with no beat loss. The beat counter does not advance.
- Mid-frame valid gaps: the granted source dropping tvalid mid-frame keeps the grant; the other port cannot preempt.
- Single-beat frame (tvalid and tlast on first beat): legal, counts as one frame.
- Frame counters: 16-bit, 0xFFFF+1 wraps to 0x0000. The two counters are independent.
- Reset mid-frame: immediate return to reset values. m_axis_tvalid drops the same cycle; the truncated frame seen by the MAC is accepted behaviour. Sources must also be reset.

Test Plan:
- Single 60-beat frame on port 0 (tlast on beat 60), m_tready=1:
  - 60 output beats with data identical and in order;
  - m_tlast only on beat 60; o_frames_0=1;
  - o_grant=01 during XFER;
  - then 12 idle cycles before o_busy falls.
- Both ports valid in the same cycle, PRIORITY_MODE=0, 3 frames each:
  - all port-0 frames go before any port-1 frame;
  - no interleaving inside a frame;
  - final o_frames_0=3, o_frames_1=3.
- Same stimulus with PRIORITY_MODE=1:
  - grant order 0,1,0,1,0,1;
  - GAP of 12 cycles between every frame.
- Random m_tready toggling (50%) during a 100-beat port-1 frame:
  - all 100 bytes delivered exactly once, in order;
  - s1_tready mirrors m_tready while granted.
- MAX_BEATS=16, port-0 frame of 20 beats:
  - output shows 16 beats, m_tlast on beat 16;
  - o_overlength pulses once;
  - beats 17-20 consumed with m_tvalid=0;
  - o_frames_0 incremented by 1.
- rst asserted at beat 30 of a 60-beat frame:
  - next cycle m_tvalid=0, o_grant=00, counters=0;
  - a fresh frame after reset passes normally.
